// File: rtl/temp_calc_multich.sv
// temp_calc_multich: time-shared multi-channel temperature calculator.
// Each accepted sample becomes tc_base + in_adc*tc_ref (mod 2^OUT_W). The
// result is then box-averaged over 2^AVG_LOG2 samples per channel, and one
// averaged reading is emitted per completed group.
// Optional alarm logic (threshold compare plus sticky per-channel flags) is
// compiled in when TEMP_CALC_ALARM_EN is defined.

module temp_calc_multich #(
   parameter  int CHANNELS = 4,
   parameter  int ADC_W    = 16,
   parameter  int REF_W    = 8,
   parameter  int OUT_W    = 32,
   parameter  int AVG_LOG2 = 2,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OUT_W-1:0]    tc_base,
   input  logic [REF_W-1:0]    tc_ref,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [ADC_W-1:0]    in_adc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH_W-1:0]     out_ch,
   output logic [OUT_W-1:0]    out_data,
`ifdef TEMP_CALC_ALARM_EN
   input  logic [OUT_W-1:0]    alarm_thresh,
   input  logic                alarm_clr,
   output logic                out_alarm,
   output logic [CHANNELS-1:0] alarm_flags,
`endif
   output logic                busy
);

   localparam int PROD_W = ADC_W + REF_W;
   localparam int ACC_W  = OUT_W + AVG_LOG2;
   localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int CHX_W  = CH_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_ACC, S_OUT} state_t;

   state_t             state_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [CH_W-1:0]    out_ch_q;
   logic [OUT_W-1:0]   out_data_q;

   // Latched input sample
   logic [CH_W-1:0]    ch_q;
   logic [ADC_W-1:0]   adc_q;
   logic [OUT_W-1:0]   base_q;
   logic [REF_W-1:0]   ref_q;
   logic [OUT_W-1:0]   temp_q;

   // Per-channel partial averages
   logic [ACC_W-1:0]   acc_q [CHANNELS];
   logic [CNT_W-1:0]   cnt_q [CHANNELS];

   logic [PROD_W-1:0]  prod_d;
   logic [OUT_W-1:0]   temp_d;
   logic [ACC_W-1:0]   acc_sel;
   logic [CNT_W-1:0]   cnt_sel;
   logic [ACC_W-1:0]   sum_d;
   logic [OUT_W-1:0]   avg_d;
   logic               ch_ok;
   logic               complete;

   // Conversion datapath, channel selection and average computation
   always_comb begin
      prod_d  = PROD_W'(adc_q) * PROD_W'(ref_q);
      temp_d  = base_q + OUT_W'(prod_d);
      acc_sel = '0;
      cnt_sel = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (ch_q == CH_W'(c)) begin
            acc_sel = acc_q[c];
            cnt_sel = cnt_q[c];
         end
      end
      // Widened compare so non-power-of-two channel counts can reject codes
      ch_ok    = ({1'b0, ch_q} < CHX_W'(CHANNELS));
      sum_d    = acc_sel + ACC_W'(temp_q);
      avg_d    = OUT_W'(sum_d >> AVG_LOG2);
      complete = (state_q == S_ACC) && ch_ok && (cnt_sel == CNT_LAST);
   end

   // Control FSM with registered handshake outputs and accumulator update
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         ch_q        <= '0;
         adc_q       <= '0;
         base_q      <= '0;
         ref_q       <= '0;
         temp_q      <= '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            acc_q[c] <= '0;
            cnt_q[c] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  ch_q       <= in_ch;
                  adc_q      <= in_adc;
                  base_q     <= tc_base;
                  ref_q      <= tc_ref;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_CALC;
               end
            end
            S_CALC: begin
               temp_q  <= temp_d;
               state_q <= S_ACC;
            end
            S_ACC: begin
               if (complete) begin
                  for (int unsigned c = 0; c < CHANNELS; c++) begin
                     if (ch_q == CH_W'(c)) begin
                        acc_q[c] <= '0;
                        cnt_q[c] <= '0;
                     end
                  end
                  out_data_q  <= avg_d;
                  out_ch_q    <= ch_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end else begin
                  if (ch_ok) begin
                     for (int unsigned c = 0; c < CHANNELS; c++) begin
                        if (ch_q == CH_W'(c)) begin
                           acc_q[c] <= sum_d;
                           cnt_q[c] <= cnt_sel + CNT_W'(1);
                        end
                     end
                  end
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

`ifdef TEMP_CALC_ALARM_EN
   logic                out_alarm_q;
   logic [CHANNELS-1:0] alarm_flags_q;
   logic                alarm_hit;

   assign alarm_hit = (avg_d > alarm_thresh);

   // Alarm registered alongside out_data; sticky flags, clear beats set
   always_ff @(posedge clk) begin
      if (rst) begin
         out_alarm_q   <= 1'b0;
         alarm_flags_q <= '0;
      end else begin
         if (complete) begin
            out_alarm_q <= alarm_hit;
         end
         if (alarm_clr) begin
            alarm_flags_q <= '0;
         end else if (complete && alarm_hit) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
               if (ch_q == CH_W'(c)) begin
                  alarm_flags_q[c] <= 1'b1;
               end
            end
         end
      end
   end

   assign out_alarm   = out_alarm_q;
   assign alarm_flags = alarm_flags_q;
`endif

endmodule

// File: tb/tb_temp_calc_multich.sv
// Directed testbench for temp_calc_multich. Main instance uses the default
// parameters; a second instance (CHANNELS=5, AVG_LOG2=0) covers the
// out-of-range channel discard and the no-averaging configuration.

module tb_temp_calc_multich;

  logic        clk;
  logic        rst;
  logic [31:0] tc_base;
  logic [7:0]  tc_ref;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [15:0] in_adc;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [31:0] out_data;
  logic        busy;

  logic        in_valid5;
  logic        in_ready5;
  logic [2:0]  in_ch5;
  logic        out_valid5;
  logic        out_ready5;
  logic [2:0]  out_ch5;
  logic [31:0] out_data5;
  logic        busy5;

`ifdef TEMP_CALC_ALARM_EN
  logic [31:0] alarm_thresh;
  logic        alarm_clr;
  logic        out_alarm;
  logic [3:0]  alarm_flags;
  logic        out_alarm5;
  logic [4:0]  alarm_flags5;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  temp_calc_multich dut (
    .clk         (clk),
    .rst         (rst),
    .tc_base     (tc_base),
    .tc_ref      (tc_ref),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_adc      (in_adc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_data    (out_data),
`ifdef TEMP_CALC_ALARM_EN
    .alarm_thresh(alarm_thresh),
    .alarm_clr   (alarm_clr),
    .out_alarm   (out_alarm),
    .alarm_flags (alarm_flags),
`endif
    .busy        (busy)
  );

  temp_calc_multich #(.CHANNELS(5), .AVG_LOG2(0)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .tc_base     (tc_base),
    .tc_ref      (tc_ref),
    .in_valid    (in_valid5),
    .in_ready    (in_ready5),
    .in_ch       (in_ch5),
    .in_adc      (in_adc),
    .out_valid   (out_valid5),
    .out_ready   (out_ready5),
    .out_ch      (out_ch5),
    .out_data    (out_data5),
`ifdef TEMP_CALC_ALARM_EN
    .alarm_thresh(alarm_thresh),
    .alarm_clr   (alarm_clr),
    .out_alarm   (out_alarm5),
    .alarm_flags (alarm_flags5),
`endif
    .busy        (busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] adc);
    int unsigned n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    in_ch    = ch;
    in_adc   = adc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic sample_nc(input logic [1:0] ch, input logic [15:0] adc);
    send(ch, adc);
    chk("nc_busy", busy, 1'b1);
    chk("nc_ready_lo", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("nc_no_out", out_valid, 1'b0);
    chk("nc_ready_back", in_ready, 1'b1);
  endtask

  task automatic sample_last(input logic [1:0] ch, input logic [15:0] adc,
                             input logic [31:0] exp, input string tag);
    send(ch, adc);
    @(negedge clk);
    chk("last_early", out_valid, 1'b0);
    @(negedge clk);
    chk("last_valid", out_valid, 1'b1);
    chk(tag, out_data, exp);
    chk("last_ch", out_ch, ch);
    chk("last_ready_lo", in_ready, 1'b0);
  endtask

  task automatic pop;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_valid_lo", out_valid, 1'b0);
    chk("pop_idle", busy, 1'b0);
    chk("pop_ready", in_ready, 1'b1);
  endtask

  task automatic check_reset_state;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ch", out_ch, 2'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    tc_base    = '0;
    tc_ref     = '0;
    in_valid   = 1'b0;
    in_ch      = '0;
    in_adc     = '0;
    out_ready  = 1'b0;
    in_valid5  = 1'b0;
    in_ch5     = '0;
    out_ready5 = 1'b0;
`ifdef TEMP_CALC_ALARM_EN
    alarm_thresh = '1;
    alarm_clr    = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    chk("rst5_ready", in_ready5, 1'b1);
    chk("rst5_valid", out_valid5, 1'b0);
`ifdef TEMP_CALC_ALARM_EN
    chk("rst_alarm", out_alarm, 1'b0);
    chk("rst_flags", alarm_flags, 4'd0);
`endif

    // 1 + 4*4 = 17, four identical samples on ch0
    tc_base = 32'd1;
    tc_ref  = 8'd4;
    sample_nc(2'd0, 16'd4);
    sample_nc(2'd0, 16'd4);
    sample_nc(2'd0, 16'd4);
    sample_last(2'd0, 16'd4, 32'd17, "basic17");
`ifdef TEMP_CALC_ALARM_EN
    chk("no_alarm", out_alarm, 1'b0);
`endif
    pop();

    // Full-width product: 0xAAAAAAAA + 0xAAAA*0xC6 = 0xAB2EAA26
    tc_base = 32'hAAAA_AAAA;
    tc_ref  = 8'hC6;
    sample_nc(2'd2, 16'hAAAA);
    sample_nc(2'd2, 16'hAAAA);
    sample_nc(2'd2, 16'hAAAA);
    sample_last(2'd2, 16'hAAAA, 32'hAB2E_AA26, "wide_prod");
    pop();

    // 0xFFFFFFFF + 1 wraps to 0
    tc_base = 32'hFFFF_FFFF;
    tc_ref  = 8'd1;
    sample_nc(2'd1, 16'd1);
    sample_nc(2'd1, 16'd1);
    sample_nc(2'd1, 16'd1);
    sample_last(2'd1, 16'd1, 32'd0, "wrap");
    pop();

    // (10+20+30+41)/4 = 101/4 -> 25
    tc_base = 32'd0;
    tc_ref  = 8'd1;
    sample_nc(2'd0, 16'd10);
    sample_nc(2'd0, 16'd20);
    sample_nc(2'd0, 16'd30);
    sample_last(2'd0, 16'd41, 32'd25, "floor");
    pop();

    // Interleaved channels stay independent
    sample_nc(2'd0, 16'd8);
    sample_nc(2'd1, 16'd16);
    sample_nc(2'd0, 16'd8);
    sample_nc(2'd1, 16'd16);
    sample_nc(2'd0, 16'd8);
    sample_nc(2'd1, 16'd16);
    sample_last(2'd0, 16'd8, 32'd8, "ilv_ch0");
    pop();
    sample_last(2'd1, 16'd16, 32'd16, "ilv_ch1");
    pop();

    // Backpressure: 0 + 5*3 = 15 held for 10 cycles with a sample pending
    tc_ref = 8'd3;
    sample_nc(2'd3, 16'd5);
    sample_nc(2'd3, 16'd5);
    sample_nc(2'd3, 16'd5);
    sample_last(2'd3, 16'd5, 32'd15, "hold_first");
    in_ch    = 2'd3;
    in_adc   = 16'd5;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, 32'd15);
      chk("hold_ch", out_ch, 2'd3);
      chk("hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    pop();
    // A sample sneaking in during the hold would complete this group early
    sample_nc(2'd3, 16'd2);
    sample_nc(2'd3, 16'd2);
    sample_nc(2'd3, 16'd2);
    sample_last(2'd3, 16'd2, 32'd6, "after_hold");
    pop();

    // Reset mid-operation: 3 samples, then a 4th aborted in CALC
    tc_base = 32'd1;
    tc_ref  = 8'd4;
    sample_nc(2'd0, 16'd4);
    sample_nc(2'd0, 16'd4);
    sample_nc(2'd0, 16'd4);
    send(2'd0, 16'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_out", out_valid, 1'b0);
`ifdef TEMP_CALC_ALARM_EN
    alarm_thresh = 32'd16;
`endif
    sample_nc(2'd0, 16'd4);
    sample_nc(2'd0, 16'd4);
    sample_nc(2'd0, 16'd4);
    sample_last(2'd0, 16'd4, 32'd17, "post_rst17");
`ifdef TEMP_CALC_ALARM_EN
    chk("alarm_out", out_alarm, 1'b1);
    chk("alarm_flag_set", alarm_flags, 4'b0001);
`endif
    pop();
`ifdef TEMP_CALC_ALARM_EN
    chk("alarm_flag_sticky", alarm_flags, 4'b0001);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    chk("alarm_flag_clr", alarm_flags, 4'b0000);
`endif

    // Second instance: channel 7 of 5 is dropped, ch4 outputs per sample
    tc_base   = 32'd0;
    tc_ref    = 8'd1;
    in_ch5    = 3'd7;
    in_adc    = 16'd100;
    in_valid5 = 1'b1;
    @(negedge clk);
    in_valid5 = 1'b0;
    chk("d5_ready_lo", in_ready5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("d5_discard_out", out_valid5, 1'b0);
    chk("d5_discard_ready", in_ready5, 1'b1);

    in_ch5    = 3'd4;
    in_adc    = 16'd9;
    in_valid5 = 1'b1;
    @(negedge clk);
    in_valid5 = 1'b0;
    @(negedge clk);
    chk("d5_early", out_valid5, 1'b0);
    @(negedge clk);
    chk("d5_valid", out_valid5, 1'b1);
    chk("d5_data", out_data5, 32'd9);
    chk("d5_ch", out_ch5, 3'd4);
    out_ready5 = 1'b1;
    @(negedge clk);
    out_ready5 = 1'b0;
    chk("d5_pop", out_valid5, 1'b0);

    // 2 + 3*5 = 17 on ch0 without averaging
    tc_base   = 32'd2;
    tc_ref    = 8'd5;
    in_ch5    = 3'd0;
    in_adc    = 16'd3;
    in_valid5 = 1'b1;
    @(negedge clk);
    in_valid5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("d5_valid2", out_valid5, 1'b1);
    chk("d5_data2", out_data5, 32'd17);
    chk("d5_ch2", out_ch5, 3'd0);
    out_ready5 = 1'b1;
    @(negedge clk);
    out_ready5 = 1'b0;
    chk("d5_idle", busy5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
